io_display_driver: RTL



---
 rtl/io_display_driver.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/io_display_driver.sv
// io_display_driver: memory-mapped driver for the eight DE2 seven-segment displays.
// A CPU write of a 32-bit value is shown either in decimal (sequential double-dabble,
// one bit per cycle) or in hexadecimal. Writes that arrive while a conversion is in
// flight land in a one-entry pending buffer (last write wins).
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   wr_en      write strobe
//   wr_data    value to display
//   wr_hex     display mode sampled with wr_en (0 decimal, 1 hexadecimal)
//   busy       high while a conversion is in progress (registered)
//   done       one-cycle pulse in the cycle after the displays update (registered)
//   HEX0..HEX7 segment outputs, bit0 = a .. bit6 = g, HEX0 least significant digit
module io_display_driver #(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        wr_hex,
  output logic        busy,
  output logic        done,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7
);

  typedef enum logic [1:0] {StIdle, StConv, StFinish} state_e;

  // Symbolic digit codes: 0..15 are hex digits, then blank and dash.
  localparam logic [4:0] CodeBlank = 5'd16;
  localparam logic [4:0] CodeDash  = 5'd17;
  localparam logic [6:0] SegBlank  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  function automatic logic [6:0] seg_of(input logic [4:0] code);
    logic [6:0] s;
    case (code)
      5'd0:    s = 7'h40;
      5'd1:    s = 7'h79;
      5'd2:    s = 7'h24;
      5'd3:    s = 7'h30;
      5'd4:    s = 7'h19;
      5'd5:    s = 7'h12;
      5'd6:    s = 7'h02;
      5'd7:    s = 7'h78;
      5'd8:    s = 7'h00;
      5'd9:    s = 7'h10;
      5'd10:   s = 7'h08;
      5'd11:   s = 7'h03;
      5'd12:   s = 7'h46;
      5'd13:   s = 7'h21;
      5'd14:   s = 7'h06;
      5'd15:   s = 7'h0E;
      5'd16:   s = 7'h7F;
      default: s = 7'h3F;
    endcase
    return SEG_ACTIVE_LOW ? s : ~s;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] bin_q, bin_d;
  logic [39:0] bcd_q, bcd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        hex_mode_q, hex_mode_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_data_q, pend_data_d;
  logic        pend_hex_q, pend_hex_d;
  logic        busy_q, done_q, done_d;
  logic        load_disp;
  logic [6:0]  seg_q [8];

  // Conversion start request shared by IDLE and the FINISH restart path.
  logic        start_en;
  logic [31:0] start_data;
  logic        start_hex;

  logic [39:0] bcd_adj;
  logic [71:0] shifted;

  always_comb begin
    state_d      = state_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    hex_mode_d   = hex_mode_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    pend_hex_d   = pend_hex_q;
    done_d       = 1'b0;
    load_disp    = 1'b0;
    start_en     = 1'b0;
    start_data   = wr_data;
    start_hex    = wr_hex;
    bcd_adj      = bcd_q;
    shifted      = '0;

    for (int i = 0; i < 10; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end

    case (state_q)
      StIdle: begin
        start_en = wr_en;
      end
      StConv: begin
        shifted = {bcd_adj, bin_q} << 1;
        bcd_d   = shifted[71:32];
        bin_d   = shifted[31:0];
        if (cnt_q == 5'd31) begin
          state_d = StFinish;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
        if (wr_en) begin
          pend_valid_d = 1'b1;
          pend_data_d  = wr_data;
          pend_hex_d   = wr_hex;
        end
      end
      StFinish: begin
        load_disp = 1'b1;
        done_d    = 1'b1;
        if (pend_valid_q) begin
          start_en     = 1'b1;
          start_data   = pend_data_q;
          start_hex    = pend_hex_q;
          pend_valid_d = wr_en;
          if (wr_en) begin
            pend_data_d = wr_data;
            pend_hex_d  = wr_hex;
          end
        end else if (wr_en) begin
          // A write landing on the FINISH edge with an empty buffer starts
          // straight away rather than taking an extra trip through IDLE.
          start_en = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_en) begin
      bin_d      = start_data;
      bcd_d      = '0;
      cnt_d      = '0;
      hex_mode_d = start_hex;
      state_d    = start_hex ? StFinish : StConv;
    end
  end

  // Display formatting, evaluated from the finished conversion state.
  logic [4:0] code [8];
  logic       seen;

  always_comb begin
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      code[i] = CodeBlank;
    end
    if (hex_mode_q) begin
      for (int i = 0; i < 8; i++) begin
        code[i] = {1'b0, bin_q[4*i +: 4]};
      end
    end else if (bcd_q[39:32] != 8'd0) begin
      for (int i = 0; i < 8; i++) begin
        code[i] = CodeDash;
      end
    end else begin
      // Walk from the most significant digit; blank until the first nonzero.
      for (int i = 7; i >= 1; i--) begin
        if (bcd_q[4*i +: 4] != 4'd0) begin
          seen = 1'b1;
        end
        code[i] = seen ? {1'b0, bcd_q[4*i +: 4]} : CodeBlank;
      end
      code[0] = {1'b0, bcd_q[3:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      bin_q        <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      hex_mode_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      pend_hex_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        seg_q[i] <= SegBlank;
      end
    end else begin
      state_q      <= state_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      hex_mode_q   <= hex_mode_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      pend_hex_q   <= pend_hex_d;
      busy_q       <= (state_d != StIdle);
      done_q       <= done_d;
      if (load_disp) begin
        for (int i = 0; i < 8; i++) begin
          seg_q[i] <= seg_of(code[i]);
        end
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign HEX0 = seg_q[0];
  assign HEX1 = seg_q[1];
  assign HEX2 = seg_q[2];
  assign HEX3 = seg_q[3];
  assign HEX4 = seg_q[4];
  assign HEX5 = seg_q[5];
  assign HEX6 = seg_q[6];
  assign HEX7 = seg_q[7];

endmodule
